mem_ctrl: RTL and testbench

//  Arbiter/sequencer for the single byte-wide RAM/IO port, shared by instruction fetch (IF) and the load/store buffer (LSB).

---
 rtl/mem_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port sequencer shared by instruction fetch and the LSB.
// One transaction at a time; LSB has priority, IF may be flushed by clear.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic [2:0]  lsb_n;
  logic [1:0]  bidx;
  logic        io_in;
  logic        io_q;

  assign lsb_n = (lsb_len == 2'd0) ? 3'd1 :
                 (lsb_len == 2'd1) ? 3'd2 : 3'd4;
  // byte sampled now was issued two edges ago
  assign bidx  = cnt_q[1:0] - 2'd2;
  assign io_in = (lsb_addr[17:16] == IO_ADDR_HI);
  assign io_q  = (addr_q[17:16] == IO_ADDR_HI);

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

  // arbitration, byte issue/collect and done generation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!if_done_q && !lsb_done_q) begin
          if (lsb_req) begin
            owner_d = 1'b1;
            addr_d  = lsb_addr;
            wdata_d = lsb_wdata;
            n_d     = lsb_n;
            buf_d   = '0;
            if (lsb_wr) begin
              state_d = WR;
              if (io_in && io_buffer_full) begin
                cnt_d = 3'd0;
              end else begin
                mem_wr_d   = 1'b1;
                mem_a_d    = lsb_addr;
                mem_dout_d = lsb_wdata[7:0];
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = RD;
              mem_a_d = lsb_addr;
              cnt_d   = 3'd1;
            end
          end else if (if_req && !clear) begin
            owner_d = 1'b0;
            addr_d  = if_addr;
            n_d     = 3'd4;
            buf_d   = '0;
            state_d = RD;
            mem_a_d = if_addr;
            cnt_d   = 3'd1;
          end
        end
      end
      RD: begin
        if (clear && !owner_q) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q < n_q) begin
            mem_a_d = addr_q + {29'd0, cnt_q};
          end
          if (cnt_q >= 3'd2) begin
            buf_d[{bidx, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == n_q + 3'd1) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (owner_q) begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      WR: begin
        if (cnt_q == n_q) begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          lsb_done_d = 1'b1;
        end else if (!(io_q && io_buffer_full)) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = addr_q + {29'd0, cnt_q};
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: RAM emulation, transaction-level model,
// directed corner cases plus randomized traffic.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_len = 2'd0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_data(if_data), .lsb_req(lsb_req), .lsb_wr(lsb_wr),
    .lsb_len(lsb_len), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        chk;
    logic [31:0] d;
  } lexp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wexp_t;

  logic [31:0] exp_if[$];
  lexp_t       exp_lsb[$];
  wexp_t       exp_wr[$];

  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  mdl [logic [31:0]];

  int          n_cmp = 0;
  int          n_err = 0;
  bit          ign_wr = 1'b0;
  logic [31:0] seen_a [4];
  int          early_wr;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rrd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] mrd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : init_byte(a);
  endfunction

  function automatic int nb(input logic [1:0] l);
    return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
  endfunction

  // little-endian, zero-extended load result from the model memory
  function automatic logic [31:0] ld_exp(input logic [31:0] a, input int n);
    logic [31:0] d;
    logic [31:0] ak;
    d = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      d[8*k +: 8] = mrd(ak);
    end
    return d;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    mdl[a] = b;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_ev(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an event expected none", nm);
  endtask

  // RAM: address seen after edge E is returned on mem_din for edge E+2
  logic [31:0] a_prev = '0;
  always @(posedge clk_in) begin
    bit en_r;
    en_r = rdy_in;
    #1;
    if (en_r) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din = rrd(a_prev);
      a_prev = mem_a;
    end
  end

  // monitor: pops expectations whenever the DUT shows a result
  lexp_t       m_le;
  wexp_t       m_we;
  logic [31:0] m_ie;
  always @(posedge clk_in) begin
    bit en_m;
    en_m = rdy_in && rst_in;
    #1;
    if (en_m) begin
      if (if_done) begin
        if (exp_if.size() == 0) fail_ev("if_done_unexpected");
        else begin
          m_ie = exp_if.pop_front();
          chk("if_data", if_data, m_ie);
        end
      end
      if (lsb_done) begin
        if (exp_lsb.size() == 0) fail_ev("lsb_done_unexpected");
        else begin
          m_le = exp_lsb.pop_front();
          if (m_le.chk) chk("lsb_rdata", lsb_rdata, m_le.d);
        end
      end
      if (mem_wr && !ign_wr) begin
        if (exp_wr.size() == 0) fail_ev("write_unexpected");
        else begin
          m_we = exp_wr.pop_front();
          chk("wr_addr", mem_a, m_we.a);
          chk("wr_data", {24'h0, mem_dout}, {24'h0, m_we.d});
        end
      end
    end
  end

  // one transaction; called at a negedge, returns at a negedge with the
  // done pulse already gone; lat = edge index of done (first edge is 1)
  task automatic txn(input bit is_if, input bit wr, input logic [1:0] len,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int io_n, input int rdy_at, input int rdy_n,
                     input int clr_at, output int lat);
    int n;
    logic [31:0] ak;
    wexp_t we;
    lexp_t le;
    n = is_if ? 4 : nb(len);
    if (is_if) begin
      exp_if.push_back(ld_exp(a, 4));
    end else if (wr) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        we.a = ak;
        we.d = wd[8*k +: 8];
        exp_wr.push_back(we);
        mdl[ak] = wd[8*k +: 8];
      end
      le.chk = 1'b0;
      le.d = '0;
      exp_lsb.push_back(le);
    end else begin
      le.chk = 1'b1;
      le.d = ld_exp(a, n);
      exp_lsb.push_back(le);
    end
    if (is_if) begin
      if_req = 1'b1;
      if_addr = a;
    end else begin
      lsb_req = 1'b1;
      lsb_wr = wr;
      lsb_len = len;
      lsb_addr = a;
      lsb_wdata = wd;
    end
    if (io_n > 0) io_buffer_full = 1'b1;
    lat = -1;
    early_wr = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk_in);
      #1;
      if (c <= 4) seen_a[c-1] = mem_a;
      if (c <= io_n && mem_wr) early_wr++;
      if ((is_if && if_done) || (!is_if && lsb_done)) begin
        lat = c;
        break;
      end
      @(negedge clk_in);
      if (c == io_n) io_buffer_full = 1'b0;
      if (c == rdy_at) rdy_in = 1'b0;
      if (c == rdy_at + rdy_n) rdy_in = 1'b1;
      if (c == clr_at) clear = 1'b1;
    end
    @(negedge clk_in);
    if_req = 1'b0;
    lsb_req = 1'b0;
    clear = 1'b0;
    io_buffer_full = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk_in);
    if (lat < 0) fail_ev("done_timeout");
  endtask

  int          lat;
  int          ld_c;
  int          if_c;
  int          base;
  int          stall;
  int          expl;
  logic [31:0] sw;
  wexp_t       twe;
  lexp_t       tle;

  initial begin
    poke(32'h0, 8'h13);
    poke(32'h1, 8'h05);
    poke(32'h2, 8'h00);
    poke(32'h3, 8'h00);
    poke(32'h102, 8'h34);
    poke(32'h103, 8'h12);
    poke(32'h200, 8'h80);
    poke(32'hFFFF_FFFE, 8'hAA);
    poke(32'hFFFF_FFFF, 8'hBB);

    // reset state
    repeat (2) @(negedge clk_in);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_if_done", {31'h0, if_done}, 32'h0);
    chk("rst_lsb_done", {31'h0, lsb_done}, 32'h0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // word fetch from 0
    txn(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 0, 0, 0, 0, lat);
    chk("if_lat", lat, 6);
    for (int k = 0; k < 4; k++) chk("if_mem_a", seen_a[k], 32'(k));

    // LSB store and IF fetch raised together
    sw = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      twe.a = 32'h100 + 32'(k);
      twe.d = sw[8*k +: 8];
      exp_wr.push_back(twe);
      mdl[twe.a] = twe.d;
    end
    tle.chk = 1'b0;
    tle.d = '0;
    exp_lsb.push_back(tle);
    exp_if.push_back(ld_exp(32'h0, 4));
    lsb_req = 1'b1;
    lsb_wr = 1'b1;
    lsb_len = 2'd2;
    lsb_addr = 32'h100;
    lsb_wdata = sw;
    if_req = 1'b1;
    if_addr = 32'h0;
    ld_c = -1;
    if_c = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_in);
      #1;
      if (lsb_done && ld_c < 0) ld_c = c;
      if (if_done && if_c < 0) if_c = c;
      if (if_c > 0) break;
      @(negedge clk_in);
      if (ld_c > 0) lsb_req = 1'b0;
    end
    @(negedge clk_in);
    if_req = 1'b0;
    lsb_req = 1'b0;
    @(negedge clk_in);
    chk("prio_lsb_lat", ld_c, 5);
    chk("prio_if_lat", if_c, 12);

    // half and byte loads
    txn(1'b0, 1'b0, 2'd1, 32'h102, 32'h0, 0, 0, 0, 0, lat);
    chk("half_lat", lat, 4);
    txn(1'b0, 1'b0, 2'd0, 32'h200, 32'h0, 0, 0, 0, 0, lat);
    chk("byte_lat", lat, 3);

    // IO store stalled by a full UART buffer for 5 cycles
    txn(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h41, 5, 0, 0, 0, lat);
    chk("io_lat", lat, 7);
    chk("io_no_early_wr", early_wr, 0);

    // clear aborts a fetch two cycles in; LSB accepted right after
    if_req = 1'b1;
    if_addr = 32'h104;
    @(posedge clk_in);
    @(negedge clk_in);
    clear = 1'b1;
    @(posedge clk_in);
    #1;
    chk("clr_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("clr_if_done", {31'h0, if_done}, 32'h0);
    @(negedge clk_in);
    clear = 1'b0;
    if_req = 1'b0;
    txn(1'b0, 1'b0, 2'd0, 32'h200, 32'h0, 0, 0, 0, 0, lat);
    chk("clr_lsb_lat", lat, 3);

    // clear has no effect on a store; read back all four bytes
    txn(1'b0, 1'b1, 2'd2, 32'h140, 32'h1357_9BDF, 0, 0, 0, 1, lat);
    chk("clr_st_lat", lat, 5);
    txn(1'b0, 1'b0, 2'd2, 32'h140, 32'h0, 0, 0, 0, 0, lat);
    chk("clr_rb_lat", lat, 6);

    // rdy_in low for 3 cycles mid fetch
    txn(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 2, 3, 0, lat);
    chk("rdy_lat", lat, 9);

    // address wrap; length 3 acts as a word
    txn(1'b0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, 0, 0, 0, 0, lat);
    chk("wrap_lat", lat, 6);
    for (int k = 0; k < 4; k++)
      chk("wrap_mem_a", seen_a[k], 32'hFFFF_FFFE + 32'(k));

    // reset in the middle of a word store
    ign_wr = 1'b1;
    lsb_req = 1'b1;
    lsb_wr = 1'b1;
    lsb_len = 2'd2;
    lsb_addr = 32'h8000;
    lsb_wdata = 32'hCAFE_F00D;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    lsb_req = 1'b0;
    #1;
    chk("mrst_mem_a", mem_a, 32'h0);
    chk("mrst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("mrst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("mrst_if_data", if_data, 32'h0);
    chk("mrst_lsb_rdata", lsb_rdata, 32'h0);
    chk("mrst_done", {30'h0, if_done, lsb_done}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("mrst_after_wr", {31'h0, mem_wr}, 32'h0);
    chk("mrst_after_done", {31'h0, lsb_done}, 32'h0);
    @(negedge clk_in);
    ign_wr = 1'b0;

    // randomized traffic with latency prediction
    for (int i = 0; i < 40; i++) begin
      int kind;
      int r;
      int io_n;
      int rdy_at;
      int rdy_n;
      int clr;
      int n;
      logic [1:0]  len;
      logic [31:0] a;
      logic [31:0] wd;
      bit is_if;
      bit wr;
      kind = $urandom_range(0, 2);
      len = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 7);
      if (r == 0) a = 32'h0003_0000 + 32'($urandom_range(0, 15));
      else if (r == 1) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'h100 + 32'($urandom_range(0, 255));
      wd = $urandom;
      io_n = $urandom_range(0, 3);
      rdy_at = $urandom_range(0, 3);
      rdy_n = $urandom_range(1, 2);
      clr = $urandom_range(0, 2);
      is_if = (kind == 0);
      wr = (kind == 2);
      n = is_if ? 4 : nb(len);
      base = is_if ? 6 : (wr ? n + 1 : n + 2);
      stall = (wr && a[17:16] == 2'b11) ? io_n : 0;
      if (stall > 0) rdy_at = 0;
      if (is_if) clr = 0;
      expl = base + stall;
      if (rdy_at > 0 && rdy_at < expl) expl = expl + rdy_n;
      txn(is_if, wr, len, a, wd, io_n, rdy_at, rdy_n, clr, lat);
      chk("rand_lat", lat, expl);
    end

    repeat (4) @(negedge clk_in);
    chk("left_if", exp_if.size(), 0);
    chk("left_lsb", exp_lsb.size(), 0);
    chk("left_wr", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
